// File: rtl/vga_frame_commit_ctrl.sv
// vga_frame_commit_ctrl
// Avalon-MM register front end for the VGA ball display. Software writes land
// in shadow registers; shadow is copied to the active display outputs only at
// the start of vertical blanking, so a frame never shows torn state.
//
// Optional feature macro: FRAME_IRQ_EN (frame-commit level interrupt).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   chipselect, write,    Avalon-MM slave; readdata valid one cycle after read
//   read, address,
//   writedata, readdata
//   hcount, vcount        raster position from vga_counters
//   bg_r, bg_g, bg_b      active background colour
//   ball_x, ball_y        active ball position
//   commit                one-cycle pulse, high the cycle the active outputs update
//   irq                   level interrupt, set on commit (tied 0 without FRAME_IRQ_EN)
//
// Register map (write -> shadow, read -> shadow except address 7):
//   0 bg_r  1 bg_g  2 bg_b  3 ball_x[7:0]  4 ball_x[9:8]  5 ball_y[7:0]  6 ball_y[8]
//   7 CTRL  write {IRQ_ACK, AUTO, ARM}, read {frame_cnt[3:0], irq, in_vblank, AUTO, pending}
module vga_frame_commit_ctrl #(
    parameter logic [9:0]  VACTIVE  = 10'd480,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter logic [7:0]  RST_BG_B = 8'h80
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           chipselect,
    input  logic           write,
    input  logic           read,
    input  logic [2:0]     address,
    input  logic [7:0]     writedata,
    output logic [7:0]     readdata,
    input  logic [10:0]    hcount,
    input  logic [9:0]     vcount,
    output logic [7:0]     bg_r,
    output logic [7:0]     bg_g,
    output logic [7:0]     bg_b,
    output logic [X_W-1:0] ball_x,
    output logic [Y_W-1:0] ball_y,
    output logic           commit,
    output logic           irq
);

    localparam logic [2:0] ADDR_CTRL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIRTY = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]     sh_r, sh_g, sh_b;
    logic [X_W-1:0] sh_x;
    logic [Y_W-1:0] sh_y;
    logic           auto_q;
    logic [3:0]     frame_cnt;
    logic [7:0]     rd_mux_c;

    logic bus_wr_c, shadow_wr_c, ctrl_wr_c, arm_wr_c;
    logic vblank_start_c, in_vblank_c, pending_c, commit_c;

    assign bus_wr_c       = chipselect && write;
    assign ctrl_wr_c      = bus_wr_c && (address == ADDR_CTRL);
    assign shadow_wr_c    = bus_wr_c && (address != ADDR_CTRL);
    assign arm_wr_c       = ctrl_wr_c && writedata[0];
    assign vblank_start_c = (vcount == VACTIVE) && (hcount == 11'd0);
    assign in_vblank_c    = (vcount >= VACTIVE);
    assign pending_c      = (state != ST_IDLE);

    // An ARM write coinciding with vblank_start commits immediately.
    assign commit_c = vblank_start_c &&
                      ((state == ST_ARMED) || (state == ST_DIRTY && auto_q) || arm_wr_c);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state; a shadow write landing on the commit cycle keeps the FSM dirty
    always_comb begin
        state_nxt = state;
        if (commit_c) begin
            state_nxt = shadow_wr_c ? ST_DIRTY : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_wr_c)         state_nxt = ST_ARMED;
                    else if (shadow_wr_c) state_nxt = ST_DIRTY;
                end
                ST_DIRTY: begin
                    if (arm_wr_c) state_nxt = ST_ARMED;
                end
                ST_ARMED: state_nxt = ST_ARMED;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Shadow registers and CTRL.AUTO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_r   <= 8'h00;
            sh_g   <= 8'h00;
            sh_b   <= RST_BG_B;
            sh_x   <= '0;
            sh_y   <= '0;
            auto_q <= 1'b0;
        end else begin
            if (shadow_wr_c) begin
                case (address)
                    3'd0: sh_r <= writedata;
                    3'd1: sh_g <= writedata;
                    3'd2: sh_b <= writedata;
                    3'd3: sh_x[7:0] <= writedata;
                    3'd4: sh_x[X_W-1:8] <= writedata[X_W-9:0];
                    3'd5: sh_y[7:0] <= writedata;
                    3'd6: sh_y[Y_W-1:8] <= writedata[Y_W-9:0];
                    default: ;
                endcase
            end
            if (ctrl_wr_c) auto_q <= writedata[1];
        end
    end

    // Active registers, commit pulse and frame counter; active takes pre-write shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_r      <= 8'h00;
            bg_g      <= 8'h00;
            bg_b      <= RST_BG_B;
            ball_x    <= '0;
            ball_y    <= '0;
            commit    <= 1'b0;
            frame_cnt <= 4'd0;
        end else begin
            commit <= commit_c;
            if (commit_c) begin
                bg_r      <= sh_r;
                bg_g      <= sh_g;
                bg_b      <= sh_b;
                ball_x    <= sh_x;
                ball_y    <= sh_y;
                frame_cnt <= frame_cnt + 4'd1;
            end
        end
    end

`ifdef FRAME_IRQ_EN
    // Frame interrupt; a commit wins over a same-cycle acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         irq <= 1'b0;
        else if (commit_c)                 irq <= 1'b1;
        else if (ctrl_wr_c && writedata[2]) irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux
    always_comb begin
        rd_mux_c = 8'h00;
        case (address)
            3'd0: rd_mux_c = sh_r;
            3'd1: rd_mux_c = sh_g;
            3'd2: rd_mux_c = sh_b;
            3'd3: rd_mux_c = sh_x[7:0];
            3'd4: rd_mux_c = 8'(sh_x[X_W-1:8]);
            3'd5: rd_mux_c = sh_y[7:0];
            3'd6: rd_mux_c = 8'(sh_y[Y_W-1:8]);
            3'd7: rd_mux_c = {frame_cnt, irq, in_vblank_c, auto_q, pending_c};
            default: rd_mux_c = 8'h00;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  readdata <= 8'h00;
        else if (chipselect && read) readdata <= rd_mux_c;
    end

endmodule

// File: tb/tb_vga_frame_commit_ctrl.sv
// Directed bench for vga_frame_commit_ctrl; raster counters are driven directly.
module tb_vga_frame_commit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write, read;
    logic [2:0]  address;
    logic [7:0]  writedata, readdata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic [9:0]  ball_x;
    logic [8:0]  ball_y;
    logic        commit, irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rd;

`ifdef FRAME_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    vga_frame_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .hcount(hcount), .vcount(vcount),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .ball_x(ball_x), .ball_y(ball_y),
        .commit(commit), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // One vblank_start cycle, then back to an active line of the next frame
    task automatic do_vblank();
        vcount = 10'd480; hcount = 11'd0;
        tick();
        vcount = 10'd10; hcount = 11'd5;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 3'd0; writedata = 8'h00; hcount = 11'd0; vcount = 10'd0;
        tick(); tick();

        // Reset values
        check("rst_bg_r", 16'(bg_r), 16'h00);
        check("rst_bg_g", 16'(bg_g), 16'h00);
        check("rst_bg_b", 16'(bg_b), 16'h80);
        check("rst_ball_x", 16'(ball_x), 16'h000);
        check("rst_ball_y", 16'(ball_y), 16'h000);
        check("rst_readdata", 16'(readdata), 16'h00);
        check("rst_commit", 16'(commit), 16'h0);
        reset = 1'b0;
        tick();
        bus_read(3'd7, rd);
        check("rst_ctrl", 16'(rd), 16'h00);
        do_vblank();
        check("frame1_no_commit", 16'(commit), 16'h0);

        // AUTO commit of bg_r at vblank_start
        vcount = 10'd100; hcount = 11'd50;
        bus_write(3'd7, 8'h02);
        bus_write(3'd0, 8'hFF);
        check("t2_bg_r_held", 16'(bg_r), 16'h00);
        bus_read(3'd7, rd);
        check("t2_ctrl_dirty", 16'(rd), 16'h03);
        vcount = 10'd479; hcount = 11'd0;
        tick();
        check("t2_bg_r_line479", 16'(bg_r), 16'h00);
        check("t2_no_commit_479", 16'(commit), 16'h0);
        do_vblank();
        check("t2_bg_r_commit", 16'(bg_r), 16'hFF);
        check("t2_commit_pulse", 16'(commit), 16'h1);
        tick();
        check("t2_commit_low", 16'(commit), 16'h0);

        // AUTO off: dirty data waits for ARM
        bus_write(3'd7, 8'h00);
        bus_write(3'd3, 8'hA5);
        bus_write(3'd4, 8'h01);
        do_vblank();
        check("t3_no_auto_commit", 16'(commit), 16'h0);
        check("t3_ball_x_held", 16'(ball_x), 16'h000);
        bus_read(3'd4, rd);
        check("t3_shadow_x_hi", 16'(rd), 16'h01);
        bus_write(3'd7, 8'h01);
        bus_read(3'd7, rd);
        check("t3_ctrl_armed", 16'(rd), 16'h11);
        do_vblank();
        check("t3_arm_commit", 16'(commit), 16'h1);
        check("t3_ball_x", 16'(ball_x), 16'h1A5);
        bus_read(3'd7, rd);
        check("t3_ctrl_after", 16'(rd), 16'h20);

        // Write on the exact vblank_start cycle: active gets old shadow
        bus_write(3'd7, 8'h02);
        bus_write(3'd0, 8'h11);
        vcount = 10'd480; hcount = 11'd0;
        chipselect = 1'b1; write = 1'b1; address = 3'd2; writedata = 8'h33;
        tick();
        chipselect = 1'b0; write = 1'b0;
        vcount = 10'd10; hcount = 11'd5;
        check("t4_commit", 16'(commit), 16'h1);
        check("t4_bg_r", 16'(bg_r), 16'h11);
        check("t4_bg_b_old", 16'(bg_b), 16'h80);
        bus_read(3'd7, rd);
        check("t4_ctrl_pending", 16'(rd), 16'h33);
        do_vblank();
        check("t4_bg_b_new", 16'(bg_b), 16'h33);

        // frame_cnt is 4 here; 13 armed commits wrap it to 1
        for (int i = 0; i < 13; i++) begin
            bus_write(3'd7, 8'h03);
            do_vblank();
            check($sformatf("t5_commit_%0d", i), 16'(commit), 16'h1);
        end
        check("t5_irq_set", 16'(irq), 16'(IRQ_ON));
        bus_read(3'd7, rd);
        check("t5_ctrl_wrap", 16'(rd), IRQ_ON ? 16'h1A : 16'h12);
        // ACK in the same cycle as a commit: set wins
        bus_write(3'd7, 8'h03);
        vcount = 10'd480; hcount = 11'd0;
        chipselect = 1'b1; write = 1'b1; address = 3'd7; writedata = 8'h06;
        tick();
        chipselect = 1'b0; write = 1'b0;
        vcount = 10'd10; hcount = 11'd5;
        check("t5_arm_vs_ack_commit", 16'(commit), 16'h1);
        check("t5_set_wins", 16'(irq), 16'(IRQ_ON));
        bus_write(3'd7, 8'h04);
        check("t5_irq_ack", 16'(irq), 16'h0);
        bus_read(3'd7, rd);
        check("t5_ctrl_acked", 16'(rd), 16'h20);

        // Reset while ARMED mid-frame
        bus_write(3'd7, 8'h01);
        bus_write(3'd1, 8'h77);
        vcount = 10'd300; hcount = 11'd20;
        reset = 1'b1;
        #1;
        check("t6_async_bg_r", 16'(bg_r), 16'h00);
        check("t6_async_bg_b", 16'(bg_b), 16'h80);
        check("t6_async_ball_x", 16'(ball_x), 16'h000);
        check("t6_async_readdata", 16'(readdata), 16'h00);
        tick();
        reset = 1'b0;
        tick();
        do_vblank();
        check("t6_no_commit", 16'(commit), 16'h0);
        check("t6_bg_g", 16'(bg_g), 16'h00);
        bus_read(3'd7, rd);
        check("t6_ctrl", 16'(rd), 16'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
